// File: rtl/uop_bist_pkg.sv
// Shared types and helpers for the exhaustive XNOR-gate BIST.
package uop_bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_t;

  localparam int unsigned MAX_N = 16;

  // Zero-extension leaves parity unchanged, so one fixed width serves every N.
  function automatic logic xnor_reduce(input logic [MAX_N-1:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/uop_delay_line.sv
// D-stage register delay line with async clear; D=0 is a plain wire.
module uop_delay_line #(
  parameter int unsigned W = 1,
  parameter int unsigned D = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (D == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q = d;
  end else begin : g_pipe
    logic [W-1:0] stage [D];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < D; i++) stage[i] <= '0;
      end else begin
        stage[0] <= d;
        for (int unsigned i = 1; i < D; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[D-1];
  end

endmodule

// File: rtl/uop_xnor_bist.sv
// Exhaustive self-checking tester for an N-input XNOR gate with programmable DUT latency.
module uop_xnor_bist
  import uop_bist_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned LAT  = 0,
  parameter int unsigned ERRW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N-1:0]    stim,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic            fail_valid,
  output logic [N-1:0]    first_fail
);

  localparam int unsigned LW         = N + 2;
  localparam int unsigned DW         = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int unsigned DRAIN_LAST = (LAT > 0) ? LAT - 1 : 0;

  bist_state_t   state_q, state_d;
  logic [N-1:0]  pat_q;
  logic [DW-1:0] drain_q;
  logic [LW-1:0] dl_in, dl_out;
  logic          last_pat_c, restart_c, mismatch_c;
  logic          dl_valid, dl_exp;
  logic [N-1:0]  dl_pat;

  assign last_pat_c = (pat_q == '1);
  assign restart_c  = start && (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_pat_c) state_d = (LAT > 0) ? DRAIN : DONE;
      DRAIN:   if (drain_q == DW'(DRAIN_LAST)) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Pattern counter wraps back to 0 on the last pattern, so stim is 0 outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                pat_q <= '0;
    else if (state_q == RUN)   pat_q <= pat_q + N'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                drain_q <= '0;
    else if (state_q == DRAIN) drain_q <= drain_q + DW'(1);
    else                       drain_q <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d == RUN) || (state_d == DRAIN);
      done <= (state_d == DONE);
    end
  end

  // Expected value and pattern travel alongside the DUT's own latency.
  assign dl_in = {state_q == RUN, xnor_reduce(MAX_N'(pat_q)), pat_q};

  uop_delay_line #(
    .W (LW),
    .D (LAT)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dl_in),
    .q     (dl_out)
  );

  assign dl_valid   = dl_out[N+1];
  assign dl_exp     = dl_out[N];
  assign dl_pat     = dl_out[N-1:0];
  assign mismatch_c = dl_valid && (dut_y != dl_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else if (state_q == IDLE || restart_c) begin
      err_count  <= '0;
      fail_valid <= 1'b0;
      first_fail <= '0;
    end else if (mismatch_c) begin
      if (err_count != '1) err_count <= err_count + ERRW'(1);
      if (!fail_valid) begin
        fail_valid <= 1'b1;
        first_fail <= dl_pat;
      end
    end
  end

  assign stim = pat_q;
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_uop_xnor_bist.sv
// Four BIST instances against fault-injectable behavioural DUTs, checked every cycle by a timeline model.
module tb_uop_xnor_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mask [4];
  logic [31:0] mcur [4];
  int          cyc  [4];
  int          checks = 0;
  int          errors = 0;

  logic [1:0] s0; logic [3:0] s1; logic [2:0] s2, s3;
  logic y0, y1, y2, y3, p1a, p1b, p3;
  logic [3:0] busy, done, pass, fv;
  logic [7:0] e0, e1, e3; logic [1:0] e2;
  logic [1:0] f0; logic [3:0] f1; logic [2:0] f2, f3;

  // Faulty DUTs: true XNOR flipped wherever the mask bit for that pattern is set.
  assign y0 = (~^s0) ^ mask[0][s0];
  assign y2 = (~^s2) ^ mask[2][s2];
  always @(posedge clk) begin
    p1a <= (~^s1) ^ mask[1][s1];
    p1b <= p1a;
    p3  <= (~^s3) ^ mask[3][s3];
  end
  assign y1 = p1b;
  assign y3 = p3;

  uop_xnor_bist #(.N(2), .LAT(0), .ERRW(8)) u0 (.clk(clk), .rst_n(rst_n), .start(start),
    .stim(s0), .dut_y(y0), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(e0), .fail_valid(fv[0]), .first_fail(f0));
  uop_xnor_bist #(.N(4), .LAT(2), .ERRW(8)) u1 (.clk(clk), .rst_n(rst_n), .start(start),
    .stim(s1), .dut_y(y1), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(e1), .fail_valid(fv[1]), .first_fail(f1));
  uop_xnor_bist #(.N(3), .LAT(0), .ERRW(2)) u2 (.clk(clk), .rst_n(rst_n), .start(start),
    .stim(s2), .dut_y(y2), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_count(e2), .fail_valid(fv[2]), .first_fail(f2));
  uop_xnor_bist #(.N(3), .LAT(1), .ERRW(8)) u3 (.clk(clk), .rst_n(rst_n), .start(start),
    .stim(s3), .dut_y(y3), .busy(busy[3]), .done(done[3]), .pass(pass[3]),
    .err_count(e3), .fail_valid(fv[3]), .first_fail(f3));

  function automatic int pn(input int i);
    case (i) 0: return 2; 1: return 4; default: return 3; endcase
  endfunction
  function automatic int pl(input int i);
    case (i) 1: return 2; 3: return 1; default: return 0; endcase
  endfunction
  function automatic int pe(input int i);
    return (i == 2) ? 2 : 8;
  endfunction
  function automatic int o_stim(input int i);
    case (i) 0: return int'(s0); 1: return int'(s1); 2: return int'(s2); default: return int'(s3); endcase
  endfunction
  function automatic int o_err(input int i);
    case (i) 0: return int'(e0); 1: return int'(e1); 2: return int'(e2); default: return int'(e3); endcase
  endfunction
  function automatic int o_ff(input int i);
    case (i) 0: return int'(f0); 1: return int'(f1); 2: return int'(f2); default: return int'(f3); endcase
  endfunction

  task automatic chk(input string nm, input int inst, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0d expected %0d at %0t", nm, inst, got, exp, $time);
    end
  endtask

  // Model position: cyc = -1 idle, else cycle number since the accepted start.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) cyc[i] = -1;
      else if (start && (cyc[i] < 0 || cyc[i] >= (1 << pn(i)) + pl(i) + 1)) begin
        cyc[i]  = 1;
        mcur[i] = mask[i];
      end else if (cyc[i] >= 1) cyc[i]++;
    end
  end

  // Outputs implied at cycle c: patterns k with k+1+LAT <= c-1 have been judged.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      int c, p, l, es, eb, ed, cnt, efv, eff, ee;
      c = rst_n ? cyc[i] : -1;
      p = 1 << pn(i);
      l = pl(i);
      es = (c >= 1 && c <= p) ? c - 1 : 0;
      eb = (c >= 1 && c <= p + l) ? 1 : 0;
      ed = (c >= p + l + 1) ? 1 : 0;
      cnt = 0; efv = 0; eff = 0;
      for (int k = 0; k < p; k++) begin
        if (c >= 0 && k <= c - 2 - l && mcur[i][k]) begin
          cnt++;
          if (efv == 0) begin efv = 1; eff = k; end
        end
      end
      ee = (cnt > (1 << pe(i)) - 1) ? (1 << pe(i)) - 1 : cnt;
      chk("stim", i, o_stim(i), es);
      chk("busy", i, int'(busy[i]), eb);
      chk("done", i, int'(done[i]), ed);
      chk("err_count", i, o_err(i), ee);
      chk("fail_valid", i, int'(fv[i]), efv);
      chk("first_fail", i, o_ff(i), eff);
      chk("pass", i, int'(pass[i]), (ed == 1 && ee == 0) ? 1 : 0);
    end
  end

  // Pulse start, optionally pulse it again in cycle 'extra', and wait for every instance to finish.
  task automatic run_and_wait(input int extra, output int b1, output int r0, output int r1);
    b1 = 0; r0 = 0; r1 = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (busy[1]) b1++;
      if (done[0] && r0 == 0) r0 = c;
      if (done[1] && r1 == 0) r1 = c;
      if (&done) break;
      start = (c == extra);
      @(negedge clk);
    end
    start = 1'b0;
    chk("all_done_in_budget", 0, int'(&done), 1);
  endtask

  task automatic set_good();
    for (int i = 0; i < 4; i++) mask[i] = '0;
  endtask

  int b1, r0, r1;

  initial begin
    for (int i = 0; i < 4; i++) begin cyc[i] = -1; mcur[i] = '0; end
    set_good();
    repeat (3) @(negedge clk);
    chk("reset_done", 1, int'(done[1]), 0);
    chk("reset_err", 0, int'(e0), 0);
    #2 rst_n = 1'b1;

    // Good DUTs: schedule and pass.
    run_and_wait(0, b1, r0, r1);
    chk("u1_busy_cycles", 1, b1, 18);
    chk("u1_done_cycle", 1, r1, 19);
    chk("u0_done_cycle", 0, r0, 5);
    chk("u0_pass", 0, int'(pass[0]), 1);
    chk("u1_pass", 1, int'(pass[1]), 1);

    // Stuck-at-0, inverting with and without saturation; restarted from DONE.
    mask[0] = 32'h9;
    mask[1] = $urandom & 32'hFFFF;
    mask[2] = 32'hFF;
    mask[3] = 32'hFF;
    run_and_wait(0, b1, r0, r1);
    chk("stuck0_err", 0, int'(e0), 2);
    chk("stuck0_first", 0, int'(f0), 0);
    chk("stuck0_fv", 0, int'(fv[0]), 1);
    chk("stuck0_pass", 0, int'(pass[0]), 0);
    chk("inv_sat_err", 2, int'(e2), 3);
    chk("inv_err", 3, int'(e3), 8);
    chk("inv_first", 3, int'(f3), 0);

    // Random fault patterns.
    repeat (8) begin
      for (int i = 0; i < 4; i++)
        mask[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom & 32'((1 << (1 << pn(i))) - 1));
      run_and_wait(0, b1, r0, r1);
    end

    // Start during RUN is ignored.
    set_good();
    run_and_wait(2, b1, r0, r1);
    chk("ignored_start_u0_done", 0, r0, 5);
    chk("ignored_start_u1_done", 1, r1, 19);
    chk("ignored_start_pass", 0, int'(pass[0]), 1);

    // Reset mid-run while u2 drives pattern 2.
    mask[2] = 32'hFF;
    mask[3] = 32'hFF;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 10 && s2 != 3'd2; c++) @(negedge clk);
    chk("reached_stim2", 2, int'(s2), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_stim", 2, int'(s2), 0);
    chk("rst_busy", 2, int'(busy[2]), 0);
    chk("rst_err", 2, int'(e2), 0);
    chk("rst_fv", 2, int'(fv[2]), 0);
    chk("rst_err3", 3, int'(e3), 0);
    chk("rst_busy1", 1, int'(busy[1]), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    set_good();
    run_and_wait(0, b1, r0, r1);
    chk("post_rst_pass", 2, int'(pass[2]), 1);
    chk("post_rst_err", 2, int'(e2), 0);
    chk("post_rst_pass3", 3, int'(pass[3]), 1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uop_xnor_bist.md
# uop_xnor_bist

Synthesisable, self-checking exhaustive tester for an N-input XNOR (even-parity) gate. On `start` it drives every input pattern 0..2^N-1 to the device under test, one per clock. It compares each DUT response against the XNOR-reduction of the pattern after a programmable pipeline latency and reports pass/fail, error count and first failing pattern. It sits beside a gate-level DUT in lab designs and replaces manual waveform inspection.

## Interface
- Clocking: one clock; reset is asynchronous and active-low.
- Parameters:
- `N`, default 2: DUT input width; N ≥ 1, N ≤ 16.
- `LAT`, default 0: DUT latency in clock cycles; 0 means a combinational DUT.
- `ERRW`, default 8: width of the error counter.
- Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a test; sampled only in IDLE or DONE.
- `stim`  out  N  pattern driven to the DUT inputs.
- `dut_y`  in  1  DUT output.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  high in DONE.
- `pass`  out  1  high when `done` is high and `err_count` is 0.
- `err_count`  out  ERRW  number of mismatches; saturates at all-ones.
- `fail_valid`  out  1  at least one mismatch recorded.
- `first_fail`  out  N  pattern of the first mismatch; valid when `fail_valid` is high.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `start` → RUN.
  - Clears `err_count`, `fail_valid` and `first_fail`.
- **RUN**
  - `stim` starts at 0 and increments by 1 each cycle.
  - After the cycle with `stim` = 2^N-1, go to DRAIN if LAT > 0, else DONE.
  - Outside RUN, `stim` = 0.
- **DRAIN**
  - Lasts exactly LAT cycles, then DONE.
  - `stim` = 0, with no compare issued for the DRAIN cycles themselves.
- **DONE**
  - Results are held.
  - `start` clears the results and goes to RUN; no pass through IDLE.
- **Expected value:** `exp` = ~^`stim`, computed in the cycle the pattern is driven.
  - `exp`, `stim` and a valid bit travel through a LAT-stage delay line.
- **Compare:**
  - Performed when the delayed valid bit is high.
  - A mismatch is `dut_y` ≠ delayed `exp`.
- **On mismatch:**
  - `err_count` increments, holding at 2^ERRW-1.
  - If `fail_valid` is 0: set it and latch the delayed `stim` into `first_fail`.
- **`start` in RUN or DRAIN:** ignored.
- **Reset** (any time, including mid-run):
  - State goes to IDLE; all outputs and pipeline stages go to 0.
  - No residual compares occur after release.

## Timing
- **Reset values:** `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `first_fail`=0.
- **Cycle numbering:** `start` sampled high at edge 0.
  - `stim`=0 during cycle 1.
  - Pattern k is driven during cycle k+1.
- **Compare timing:** pattern k is compared at the edge ending cycle k+1+LAT.
  - For LAT=0, `dut_y` is sampled in the same cycle the pattern is driven.
- **`busy`:** high for 2^N+LAT cycles.
- **`done`:** rises in cycle 2^N+LAT+1 and stays high until the next accepted `start` or reset.
- **`pass`:** combinational from the registered `done` and `err_count`; no extra latency.
- **Mismatch on the last compare:** already reflected in `err_count` when `done` rises.
- **Restart from DONE:** `done` falls and `busy` rises in the same cycle.

## Structure
- Package `uop_bist_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_t`.
  - Function `xnor_reduce`.
- Sub-module `uop_delay_line`:
  - Parameters `W` and `D`.
  - D registers with async active-low clear; D=0 is a wire pass-through.
  - Instantiated once, with W = N+2 to carry `stim`, `exp` and valid.
- Top level holds the FSM, pattern counter, drain counter and result registers.

## Test plan
- **Good DUT, combinational:** N=2, LAT=0, 2-input XNOR; pulse `start`.
  - `stim` runs 0,1,2,3 in cycles 1–4.
  - `done` rises in cycle 5 with `pass`=1 and `err_count`=0.
- **Stuck-at-0 DUT:** N=2, LAT=0, `dut_y` tied to 0.
  - `err_count`=2, `first_fail`=0, `fail_valid`=1, `pass`=0.
- **Good DUT, pipelined:** N=4, LAT=2, two-stage registered XNOR-reduction model.
  - `busy` is high for 18 cycles.
  - `done` rises in cycle 19 with `pass`=1.
- **Inverting DUT, counter saturation:** N=3, LAT=0, DUT = XOR-reduction.
  - With ERRW=8: `err_count`=8, `first_fail`=0.
  - With ERRW=2: `err_count`=3.
- **Reset mid-run:** N=3; assert `rst_n`=0 while `stim`=2.
  - All outputs are 0 immediately.
  - After release, a new `start` gives a full run of 8 patterns ending with `pass`=1.
- **Restart rules:** pulse `start` while `stim`=1 in RUN → no effect; `done` rises on schedule.
  - A `start` in DONE clears the results and reruns from `stim`=0.
